// File: rtl/adder_arb_pkg.sv
// Shared definitions for the adder-sharing arbiter: data width, statistics width
// and the sequencer state type.
package adder_arb_pkg;

  localparam int DATA_W = 8;
  localparam int STAT_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage : adder_arb_pkg

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: picks the first requester above last_grant,
// wrapping modulo N, and reports it both one-hot and as an index.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last_grant,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             any_req
);

  logic found;
  int   idx;

  // NOTE: every signal written here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    any_req   = |req;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(last_grant) + k) % N;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = IDX_W'(idx);
      end
    end
  end

endmodule : rr_arbiter

// File: rtl/adder_share_arbiter.sv
// Round-robin sequencer sharing one registered 8-bit adder among NUM_REQ clients.
// Optional statistics counters are enabled by defining ADDER_ARB_STATS_EN.
module adder_share_arbiter
  import adder_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ADD_LAT = 1,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_a,
  input  logic [NUM_REQ*DATA_W-1:0] req_b,
  input  logic [NUM_REQ-1:0]        req_cin,
  output logic [DATA_W-1:0]         add_a,
  output logic [DATA_W-1:0]         add_b,
  output logic                      add_cin,
  input  logic [DATA_W-1:0]         add_sum,
  input  logic                      add_cout,
  output logic                      resp_valid,
  input  logic                      resp_ready,
  output logic [ID_W-1:0]           resp_id,
  output logic [DATA_W-1:0]         resp_sum,
  output logic                      resp_cout,
  output logic                      busy
`ifdef ADDER_ARB_STATS_EN
  ,
  output logic [STAT_W-1:0]         stat_ops,
  output logic [STAT_W-1:0]         stat_stall
`endif
);

  localparam int CNT_W = (ADD_LAT < 1) ? 1 : $clog2(ADD_LAT + 1);

  state_e             state;
  logic [ID_W-1:0]    last_grant;
  logic [ID_W-1:0]    cur_id;
  logic [CNT_W-1:0]   cnt;
  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_idx;
  logic               any_req;

  rr_arbiter #(
    .N     (NUM_REQ),
    .IDX_W (ID_W)
  ) u_rr_arbiter (
    .req        (req_valid),
    .last_grant (last_grant),
    .grant      (grant),
    .grant_idx  (grant_idx),
    .any_req    (any_req)
  );

  // Grant is offered only while idle, so the handshake lasts exactly one cycle.
  assign req_ready  = (state == IDLE) ? grant : '0;
  assign resp_valid = (state == RESP);
  assign busy       = (state != IDLE);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; all are cleared because the adder operands are outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= ID_W'(NUM_REQ - 1);
      cur_id     <= '0;
      cnt        <= '0;
      add_a      <= '0;
      add_b      <= '0;
      add_cin    <= 1'b0;
      resp_id    <= '0;
      resp_sum   <= '0;
      resp_cout  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            add_a      <= req_a[int'(grant_idx)*DATA_W +: DATA_W];
            add_b      <= req_b[int'(grant_idx)*DATA_W +: DATA_W];
            add_cin    <= req_cin[grant_idx];
            cur_id     <= grant_idx;
            last_grant <= grant_idx;
            cnt        <= CNT_W'(ADD_LAT);
            state      <= BUSY;
          end
        end
        BUSY: begin
          // Operands stay on the adder until the fixed latency has elapsed.
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            resp_sum  <= add_sum;
            resp_cout <= add_cout;
            resp_id   <= cur_id;
            state     <= RESP;
          end
        end
        RESP: begin
          if (resp_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ADDER_ARB_STATS_EN
  // Saturating event counters; they stick at all-ones rather than wrapping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_ops   <= '0;
      stat_stall <= '0;
    end else begin
      if (resp_valid && resp_ready && (stat_ops != '1)) begin
        stat_ops <= stat_ops + 1'b1;
      end
      if (resp_valid && !resp_ready && (stat_stall != '1)) begin
        stat_stall <= stat_stall + 1'b1;
      end
    end
  end
`endif

endmodule : adder_share_arbiter
